// File: rtl/ft600_pkg.sv
// rtl/ft600_pkg.sv - FT600 bus scheduler shared types and width constants
package ft600_pkg;

  localparam int DATA_W = 16;
  localparam int BE_W   = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_RD_OE = 3'd2,
    ST_READ  = 3'd3,
    ST_TURN  = 3'd4
  } state_t;

  typedef enum logic {
    GRANT_WRITE = 1'b0,
    GRANT_READ  = 1'b1
  } grant_t;

endpackage

// File: rtl/ft600_bus_scheduler.sv
// rtl/ft600_bus_scheduler.sv - FT600 245-mode bus arbiter: round-robin read/write bursts with turnaround
module ft600_bus_scheduler
  import ft600_pkg::*;
#(
  parameter int   MAX_BURST = 256,
  parameter logic RR_INIT   = 1'b0
) (
  input  logic              ftdi_clk,
  input  logic              rst,
  input  logic              ftdi_rxf_n,
  input  logic              ftdi_txe_n,
  output logic              ftdi_oe_n,
  output logic              ftdi_rd_n,
  output logic              ftdi_wr_n,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  input  logic [BE_W-1:0]   be_i,
  output logic [BE_W-1:0]   be_o,
  output logic              bus_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [BE_W-1:0]   tx_be,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic [BE_W-1:0]   rx_be,
  output logic              rx_valid,
  input  logic              rx_afull,
  output logic              busy
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  state_t           state_q, state_d;
  grant_t           last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rd_ok, wr_ok;
  logic             rd_beat, wr_beat;

  assign rd_ok = ~ftdi_rxf_n & ~rx_afull;
  assign wr_ok = tx_valid & ~ftdi_txe_n;
  assign busy  = (state_q != ST_IDLE);

  always_ff @(posedge ftdi_clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      last_q  <= grant_t'(RR_INIT);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    ftdi_oe_n = 1'b1;
    ftdi_rd_n = 1'b1;
    ftdi_wr_n = 1'b1;
    bus_oe    = 1'b0;
    tx_ready  = 1'b0;
    data_o    = '0;
    be_o      = '0;
    rd_beat   = 1'b0;
    wr_beat   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // On a tie the side that did not hold the bus last wins.
        if (rd_ok && (!wr_ok || last_q == GRANT_WRITE)) begin
          state_d = ST_RD_OE;
          last_d  = GRANT_READ;
          cnt_d   = '0;
        end else if (wr_ok) begin
          state_d = ST_WRITE;
          last_d  = GRANT_WRITE;
          cnt_d   = '0;
        end
      end
      ST_WRITE: begin
        bus_oe    = 1'b1;
        tx_ready  = ~ftdi_txe_n;
        wr_beat   = wr_ok;
        ftdi_wr_n = ~wr_beat;
        data_o    = tx_data;
        be_o      = tx_be;
        if (!wr_beat || cnt_q == LAST_BEAT) state_d = ST_TURN;
        if (wr_beat) cnt_d = cnt_q + CNT_W'(1);
      end
      ST_RD_OE: begin
        // The FT600 needs OE_N asserted one cycle before the first RD_N.
        ftdi_oe_n = 1'b0;
        state_d   = ST_READ;
      end
      ST_READ: begin
        ftdi_oe_n = 1'b0;
        rd_beat   = rd_ok;
        ftdi_rd_n = ~rd_beat;
        if (!rd_beat || cnt_q == LAST_BEAT) state_d = ST_TURN;
        if (rd_beat) cnt_d = cnt_q + CNT_W'(1);
      end
      ST_TURN: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ftdi_clk) begin
    if (rst) begin
      rx_valid <= 1'b0;
      rx_data  <= '0;
      rx_be    <= '0;
    end else begin
      rx_valid <= rd_beat;
      if (rd_beat) begin
        rx_data <= data_i;
        rx_be   <= be_i;
      end
    end
  end

endmodule

// File: tb/tb_ft600_bus_scheduler.sv
// tb/tb_ft600_bus_scheduler.sv - directed and randomized checks for ft600_bus_scheduler
module tb_ft600_bus_scheduler;

  localparam int MB = 4;

  logic        ftdi_clk = 1'b0;
  logic        rst = 1'b1;
  logic        ftdi_rxf_n = 1'b1, ftdi_txe_n = 1'b1;
  logic        ftdi_oe_n, ftdi_rd_n, ftdi_wr_n;
  logic [15:0] data_i = '0, data_o, tx_data = '0, rx_data;
  logic [1:0]  be_i = '0, be_o, tx_be = '0, rx_be;
  logic        bus_oe, tx_valid = 1'b0, tx_ready, rx_valid, rx_afull = 1'b0, busy;

  int passed = 0;
  int total  = 0;

  ft600_bus_scheduler #(.MAX_BURST(MB), .RR_INIT(1'b0)) dut (
    .ftdi_clk(ftdi_clk), .rst(rst), .ftdi_rxf_n(ftdi_rxf_n), .ftdi_txe_n(ftdi_txe_n),
    .ftdi_oe_n(ftdi_oe_n), .ftdi_rd_n(ftdi_rd_n), .ftdi_wr_n(ftdi_wr_n),
    .data_i(data_i), .data_o(data_o), .be_i(be_i), .be_o(be_o), .bus_oe(bus_oe),
    .tx_data(tx_data), .tx_be(tx_be), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_be(rx_be), .rx_valid(rx_valid), .rx_afull(rx_afull), .busy(busy)
  );

  always #5 ftdi_clk = ~ftdi_clk;

  always @(negedge ftdi_clk) begin
    total++;
    assert (!(bus_oe && !ftdi_oe_n)) passed++;
    else $error("FAIL bus_contention observed bus_oe=%0b oe_n=%0b expected never both active", bus_oe, ftdi_oe_n);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge ftdi_clk);
    #1;
  endtask

  // Expected {busy,bus_oe,oe_n,rd_n,wr_n} for each bus phase:
  // I idle, O output-enable only, R read beat, W write beat, T turnaround
  function automatic logic [4:0] phase_vec(input byte p);
    case (p)
      "I":     return 5'b00111;
      "O":     return 5'b10011;
      "R":     return 5'b10001;
      "W":     return 5'b11110;
      default: return 5'b10111;
    endcase
  endfunction

  task automatic check_phase(input string tag, input byte p);
    check(tag, {27'd0, busy, bus_oe, ftdi_oe_n, ftdi_rd_n, ftdi_wr_n}, {27'd0, phase_vec(p)});
  endtask

  task automatic quiet_inputs();
    ftdi_rxf_n = 1'b1; ftdi_txe_n = 1'b1; tx_valid = 1'b0; rx_afull = 1'b0;
  endtask

  task automatic do_reset();
    quiet_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] wwords [4];
    logic [15:0] rwords [3];
    string       seq;
    logic [15:0] tx_word;
    logic        prev_rd;
    logic [15:0] prev_data;
    logic [1:0]  prev_be;
    int          beats, rd_total, wr_total;

    wwords[0] = 16'h3130; wwords[1] = 16'h3332; wwords[2] = 16'h3534; wwords[3] = 16'h3736;
    rwords[0] = 16'hAAAA; rwords[1] = 16'hBBBB; rwords[2] = 16'hCCCC;

    // Reset state
    quiet_inputs();
    tick();
    check_phase("reset_strobes", "I");
    check("reset_tx_ready", {31'd0, tx_ready}, 32'd0);
    check("reset_rx", {13'd0, rx_valid, rx_be, rx_data}, 32'd0);
    rst = 1'b0;

    // Write-only burst of four beats
    tx_valid = 1'b1; ftdi_txe_n = 1'b0; tx_data = wwords[0]; tx_be = 2'b11;
    #1 check_phase("wr_idle", "I");
    tick();
    for (int i = 0; i < 4; i++) begin
      tx_data = wwords[i];
      #1 check_phase($sformatf("wr_beat%0d", i), "W");
      check($sformatf("wr_data%0d", i), {14'd0, be_o, data_o}, {14'd0, 2'b11, wwords[i]});
      check($sformatf("wr_ready%0d", i), {31'd0, tx_ready}, 32'd1);
      tick();
    end
    tx_valid = 1'b0;
    #1 check_phase("wr_turn", "T");
    check("wr_turn_data", {16'd0, data_o}, 32'd0);
    tick();
    check_phase("wr_back_idle", "I");

    // Read-only burst of three beats
    ftdi_txe_n = 1'b1; ftdi_rxf_n = 1'b0;
    tick();
    check_phase("rd_oe", "O");
    tick();
    for (int i = 0; i < 3; i++) begin
      data_i = rwords[i]; be_i = 2'(i + 1);
      #1 check_phase($sformatf("rd_beat%0d", i), "R");
      if (i == 0) check("rd_first_rx_valid", {31'd0, rx_valid}, 32'd0);
      else check($sformatf("rd_rx%0d", i - 1), {13'd0, rx_valid, rx_be, rx_data}, {13'd0, 1'b1, 2'(i), rwords[i - 1]});
      tick();
    end
    ftdi_rxf_n = 1'b1;
    #1 check_phase("rd_empty", "O");
    check("rd_rx2", {13'd0, rx_valid, rx_be, rx_data}, {13'd0, 1'b1, 2'd3, rwords[2]});
    tick();
    check_phase("rd_turn", "T");
    check("rd_turn_rx_valid", {31'd0, rx_valid}, 32'd0);
    tick();
    check_phase("rd_back_idle", "I");

    // Both sides pending: reads win the first tie, then bursts alternate
    do_reset();
    ftdi_rxf_n = 1'b0; ftdi_txe_n = 1'b0; tx_valid = 1'b1;
    seq = "IORRRRTIWWWWTIO";
    for (int i = 0; i < seq.len(); i++) begin
      #1 check_phase($sformatf("rr_cycle%0d", i), seq[i]);
      tick();
    end

    // Write stalled by txe_n after two beats
    do_reset();
    ftdi_txe_n = 1'b0; tx_valid = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      #1 check_phase($sformatf("stall_wr%0d", i), "W");
      tick();
    end
    ftdi_txe_n = 1'b1;
    #1 check("stall_wr_withheld", {30'd0, ftdi_wr_n, tx_ready}, 32'b10);
    tick();
    check_phase("stall_wr_turn", "T");
    tick();

    // Read stalled by rx_afull
    quiet_inputs(); ftdi_rxf_n = 1'b0;
    #1 check_phase("stall_rd_idle", "I");
    tick(); tick();
    check_phase("stall_rd_beat", "R");
    tick();
    rx_afull = 1'b1;
    #1 check_phase("stall_rd_afull", "O");
    tick();
    check_phase("stall_rd_turn", "T");
    tick();

    // Reset during the second read beat
    quiet_inputs(); ftdi_rxf_n = 1'b0;
    tick(); tick(); tick();
    check_phase("rst_mid_beat2", "R");
    rst = 1'b1;
    tick();
    check("rst_mid_abort", {29'd0, busy, rx_valid, ftdi_oe_n}, 32'b001);
    rst = 1'b0;

    // Randomized traffic against stream/bus rules
    do_reset();
    tx_word = 16'($urandom);
    prev_rd = 1'b0; prev_data = '0; prev_be = '0;
    beats = 0; rd_total = 0; wr_total = 0;
    for (int n = 0; n < 3000; n++) begin
      ftdi_rxf_n = ($urandom_range(0, 3) == 0);
      ftdi_txe_n = ($urandom_range(0, 3) == 0);
      tx_valid   = ($urandom_range(0, 3) != 0);
      rx_afull   = ($urandom_range(0, 7) == 0);
      data_i     = 16'($urandom);
      be_i       = 2'($urandom);
      tx_data    = tx_word;
      tx_be      = tx_word[1:0];
      #1;
      check("rnd_rx_valid", {31'd0, rx_valid}, {31'd0, prev_rd});
      if (prev_rd) check("rnd_rx_data", {14'd0, rx_be, rx_data}, {14'd0, prev_be, prev_data});
      if (!ftdi_rd_n) check("rnd_rd_legal", {28'd0, ftdi_rxf_n, rx_afull, ftdi_oe_n, bus_oe}, 32'd0);
      if (!ftdi_wr_n)
        check("rnd_wr", {13'd0, ftdi_txe_n, tx_valid, bus_oe, be_o, data_o}, {13'd0, 1'b0, 1'b1, 1'b1, tx_word[1:0], tx_word});
      check("rnd_handshake", {31'd0, tx_ready & tx_valid}, {31'd0, ~ftdi_wr_n});
      if (!busy) beats = 0;
      else if (!ftdi_rd_n || !ftdi_wr_n) begin
        beats++;
        check("rnd_burst_len", {31'd0, beats <= MB}, 32'd1);
      end
      if (!ftdi_rd_n) rd_total++;
      if (!ftdi_wr_n) wr_total++;
      if (tx_valid && tx_ready) tx_word = tx_word + 16'd1;
      prev_rd = ~ftdi_rd_n; prev_data = data_i; prev_be = be_i;
      tick();
    end
    check("rnd_progress", {31'd0, (rd_total > 100) && (wr_total > 100)}, 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
